// File: rtl/t05_regfile_sb.sv
// Register file with NUM_RD combinational read ports, write/load bypass,
// and a pending-load scoreboard for load-use stalls and WAW detection.

// One read port: zero register, ALU bypass, load bypass, then array contents.
// busy is suppressed when the pending load lands in this very cycle.
module t05_regfile_sb_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              pend,
  output logic [DATA_W-1:0] data,
  output logic              busy
);
  logic zero_addr, wr_hit, ld_hit;

  assign zero_addr = (addr == '0);
  assign wr_hit    = wr_en && (wr_addr == addr);
  assign ld_hit    = ld_en && (ld_addr == addr);

  // Priority select: zero reg, ALU result (younger), load data, stored value
  always_comb begin
    data = reg_data;
    if (zero_addr)   data = '0;
    else if (wr_hit) data = wr_data;
    else if (ld_hit) data = ld_data;
  end

  // pend is never set for reg 0, so no explicit zero check is needed here
  assign busy = pend && !ld_hit;
endmodule

module t05_regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     stall,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     ld_en,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [DATA_W-1:0]        ld_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_rd,
  output logic [ADDR_W:0]          pending_cnt,
  output logic                     waw_err
);
  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             pend, pend_nxt;
  logic [ADDR_W:0]                 cnt_nxt;
  logic                            waw_nxt;

  // Read ports
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[i*ADDR_W +: ADDR_W];
    t05_regfile_sb_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rd (
      .addr    (a),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .ld_en   (ld_en),
      .ld_addr (ld_addr),
      .ld_data (ld_data),
      .reg_data(regs[a]),
      .pend    (pend[a]),
      .data    (rd_data[i*DATA_W +: DATA_W]),
      .busy    (rd_busy[i])
    );
  end

  assign stall = |rd_busy;

  // Next pending bits: issue set beats a same-cycle load clear; reg 0 stays clear
  always_comb begin
    pend_nxt = pend;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (issue_en && issue_rd == ADDR_W'(r))   pend_nxt[r] = 1'b1;
      else if (ld_en && ld_addr == ADDR_W'(r))  pend_nxt[r] = 1'b0;
    end
    pend_nxt[0] = 1'b0;
  end

  // Popcount of the post-edge pending set
  always_comb begin
    cnt_nxt = '0;
    for (int r = 0; r < NUM_REGS; r++)
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, pend_nxt[r]};
  end

  // WAW: ALU write onto a pending reg, or re-issue onto a pending reg not landing now
  always_comb begin
    waw_nxt = 1'b0;
    if (wr_en && wr_addr != '0 && pend[wr_addr]) waw_nxt = 1'b1;
    if (issue_en && issue_rd != '0 && pend[issue_rd] &&
        !(ld_en && ld_addr == issue_rd))         waw_nxt = 1'b1;
  end

  // Register array: load first, ALU write last so it wins on a collision
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '0;
    end else begin
      if (ld_en && ld_addr != '0) regs[ld_addr] <= ld_data;
      if (wr_en && wr_addr != '0) regs[wr_addr] <= wr_data;
    end
  end

  // Scoreboard state and its registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      pend        <= '0;
      pending_cnt <= '0;
      waw_err     <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      pending_cnt <= cnt_nxt;
      waw_err     <= waw_nxt;
    end
  end
endmodule
